// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by the picker and the arbiter top.
package dmem_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 32;
    localparam int STARVE_CNT_W = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way combinational picker: round-robin on last winner,
// or port-0 priority with a forced port-1 override.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    input  logic       force1,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req != 2'b11) begin
            gnt = req;
        end else if (mode) begin
            gnt = force1 ? 2'b10 : 2'b01;
        end else begin
            gnt = (last == PORT0) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory,
// with lock ownership, starvation guard and registered read return.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int PRIO_MODE  = 0,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_lock,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_lock,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic MODE = (PRIO_MODE == 1);
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM =
        STARVE_CNT_W'(STARVE_MAX);

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    logic       force1;

    assign force1 = MODE && (starve_q >= STARVE_LIM);

    rr_pick2 u_pick (
        .req    ({p1_req, p0_req}),
        .last   (last_q),
        .mode   (MODE),
        .force1 (force1),
        .gnt    (pick_gnt)
    );

    // Owner states grant only the owner, even when it idles a cycle.
    always_comb begin
        gnt = 2'b00;
        unique case (state_q)
            OWN0:    gnt = {1'b0, p0_req};
            OWN1:    gnt = {p1_req, 1'b0};
            default: gnt = pick_gnt;
        endcase
        if (!rst_n) gnt = 2'b00;
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt[0]) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_we    = p0_we;
        end else if (gnt[1]) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_we    = p1_we;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        starve_d  = starve_q;
        rvalid0_d = gnt[0] & ~p0_we;
        rvalid1_d = gnt[1] & ~p1_we;
        rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;

        unique case (state_q)
            OWN0: if (!p0_lock) state_d = IDLE;
            OWN1: if (!p1_lock) state_d = IDLE;
            default: begin
                if (gnt[0] && p0_lock) state_d = OWN0;
                else if (gnt[1] && p1_lock) state_d = OWN1;
            end
        endcase

        if (gnt[0]) last_d = PORT0;
        else if (gnt[1]) last_d = PORT1;

        if (gnt[1]) starve_d = '0;
        else if (p1_req && starve_q != '1) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= PORT1;
            starve_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            starve_q  <= starve_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin instance with a memory
// model, plus a priority instance for the starvation guard.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req_a, p0_we_a, p0_lock_a;
    logic [31:0] p0_addr_a, p0_wdata_a;
    logic        p0_gnt_a, p0_rvalid_a;
    logic [31:0] p0_rdata_a;
    logic        p1_req_a, p1_we_a, p1_lock_a;
    logic [31:0] p1_addr_a, p1_wdata_a;
    logic        p1_gnt_a, p1_rvalid_a;
    logic [31:0] p1_rdata_a;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        mem_we_a;

    logic        p0_req_b, p0_we_b, p0_lock_b;
    logic [31:0] p0_addr_b, p0_wdata_b;
    logic        p0_gnt_b, p0_rvalid_b;
    logic [31:0] p0_rdata_b;
    logic        p1_req_b, p1_we_b, p1_lock_b;
    logic [31:0] p1_addr_b, p1_wdata_b;
    logic        p1_gnt_b, p1_rvalid_b;
    logic [31:0] p1_rdata_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        mem_we_b;

    dmem_arbiter u_a (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req_a), .p0_we(p0_we_a), .p0_lock(p0_lock_a),
        .p0_addr(p0_addr_a), .p0_wdata(p0_wdata_a),
        .p0_gnt(p0_gnt_a), .p0_rvalid(p0_rvalid_a),
        .p0_rdata(p0_rdata_a),
        .p1_req(p1_req_a), .p1_we(p1_we_a), .p1_lock(p1_lock_a),
        .p1_addr(p1_addr_a), .p1_wdata(p1_wdata_a),
        .p1_gnt(p1_gnt_a), .p1_rvalid(p1_rvalid_a),
        .p1_rdata(p1_rdata_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_we(mem_we_a), .mem_rdata(mem_rdata_a)
    );

    dmem_arbiter #(.PRIO_MODE(1), .STARVE_MAX(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req_b), .p0_we(p0_we_b), .p0_lock(p0_lock_b),
        .p0_addr(p0_addr_b), .p0_wdata(p0_wdata_b),
        .p0_gnt(p0_gnt_b), .p0_rvalid(p0_rvalid_b),
        .p0_rdata(p0_rdata_b),
        .p1_req(p1_req_b), .p1_we(p1_we_b), .p1_lock(p1_lock_b),
        .p1_addr(p1_addr_b), .p1_wdata(p1_wdata_b),
        .p1_gnt(p1_gnt_b), .p1_rvalid(p1_rvalid_b),
        .p1_rdata(p1_rdata_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_we(mem_we_b), .mem_rdata(mem_rdata_b)
    );

    logic [31:0] mem_a [0:63];
    assign mem_rdata_a = mem_a[mem_addr_a[7:2]];
    always @(posedge clk)
        if (mem_we_a) mem_a[mem_addr_a[7:2]] <= mem_wdata_a;

    assign mem_rdata_b = ~mem_addr_b;

    typedef struct {
        logic        r0, w0, l0;
        logic [31:0] a0, d0;
        logic        r1, w1, l1;
        logic [31:0] a1, d1;
        logic        g0, g1, we;
        logic [31:0] ma, x0, x1;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int nvec = 0;
    int nerr = 0;

    function automatic vec_t mk(
        logic r0, logic w0, logic l0, logic [31:0] a0, logic [31:0] d0,
        logic r1, logic w1, logic l1, logic [31:0] a1, logic [31:0] d1,
        logic g0, logic g1, logic we, logic [31:0] ma,
        logic [31:0] x0, logic [31:0] x1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = we; v.ma = ma;
        v.x0 = x0; v.x1 = x1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        p0_req_a = v.r0; p0_we_a = v.w0; p0_lock_a = v.l0;
        p0_addr_a = v.a0; p0_wdata_a = v.d0;
        p1_req_a = v.r1; p1_we_a = v.w1; p1_lock_a = v.l1;
        p1_addr_a = v.a1; p1_wdata_a = v.d1;
    endtask

    task automatic idle_b();
        p0_req_b = 0; p0_we_b = 0; p0_lock_b = 0;
        p0_addr_b = 0; p0_wdata_b = 0;
        p1_req_b = 0; p1_we_b = 0; p1_lock_b = 0;
        p1_addr_b = 0; p1_wdata_b = 0;
    endtask

    // Read returns: rvalid must match what the bench expects pending.
    task automatic chk_rv(input int i);
        chk($sformatf("v%0d p0_rvalid", i), 32'(p0_rvalid_a),
            32'(q0.size() != 0));
        if (q0.size() != 0)
            chk($sformatf("v%0d p0_rdata", i), p0_rdata_a, q0.pop_front());
        chk($sformatf("v%0d p1_rvalid", i), 32'(p1_rvalid_a),
            32'(q1.size() != 0));
        if (q1.size() != 0)
            chk($sformatf("v%0d p1_rdata", i), p1_rdata_a, q1.pop_front());
    endtask

    initial begin
        vec_t z;
        logic [31:0] exp_wd;
        z = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0);
        for (int i = 0; i < 64; i++) mem_a[i] = 32'h0;
        mem_a[0] = 32'hA;
        mem_a[1] = 32'hB;
        mem_a[4] = 32'h1234;
        drive_a(z);
        idle_b();

        // reset state with a request pending
        #12;
        p0_req_a = 1'b1;
        p0_addr_a = 32'h4;
        #1;
        chk("rst p0_gnt", 32'(p0_gnt_a), 0);
        chk("rst mem_we", 32'(mem_we_a), 0);
        chk("rst p0_rvalid", 32'(p0_rvalid_a), 0);
        chk("rst p0_rdata", p0_rdata_a, 0);
        drive_a(z);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        tbl.push_back(mk(1,0,0,0,0,      1,0,0,4,0,      1,0,0,0,    32'hA,0));
        tbl.push_back(mk(1,0,0,0,0,      1,0,0,4,0,      0,1,0,4,    0,32'hB));
        tbl.push_back(mk(1,0,0,0,0,      1,0,0,4,0,      1,0,0,0,    32'hA,0));
        tbl.push_back(mk(1,0,0,0,0,      1,0,0,4,0,      0,1,0,4,    0,32'hB));
        tbl.push_back(z);
        tbl.push_back(z);
        tbl.push_back(mk(1,1,0,'h40,'hDEAD, 0,0,0,0,0,   1,0,1,'h40, 0,0));
        tbl.push_back(mk(0,0,0,0,0,      1,0,0,'h40,0,   0,1,0,'h40, 0,32'hDEAD));
        tbl.push_back(z);
        tbl.push_back(mk(0,0,0,0,0,      1,1,1,'h20,'h11, 0,1,1,'h20, 0,0));
        tbl.push_back(mk(1,0,0,0,0,      1,1,1,'h24,'h22, 0,1,1,'h24, 0,0));
        tbl.push_back(mk(1,0,0,0,0,      0,0,1,0,0,      0,0,0,0,    0,0));
        tbl.push_back(mk(1,0,0,0,0,      1,1,0,'h28,'h33, 0,1,1,'h28, 0,0));
        tbl.push_back(mk(1,0,0,0,0,      0,0,0,0,0,      1,0,0,0,    32'hA,0));
        tbl.push_back(mk(0,0,0,0,0,      1,0,0,'h24,0,   0,1,0,'h24, 0,32'h22));
        tbl.push_back(mk(1,0,0,'h20,0,   1,0,0,'h28,0,   1,0,0,'h20, 32'h11,0));
        tbl.push_back(mk(1,0,0,'h20,0,   1,0,0,'h28,0,   0,1,0,'h28, 0,32'h33));
        tbl.push_back(z);
        tbl.push_back(mk(1,0,1,4,0,      1,0,0,0,0,      1,0,0,4,    32'hB,0));
        tbl.push_back(mk(0,0,1,0,0,      1,0,0,0,0,      0,0,0,0,    0,0));
        tbl.push_back(mk(1,0,0,0,0,      1,0,0,0,0,      1,0,0,0,    32'hA,0));
        tbl.push_back(mk(0,0,0,0,0,      1,0,0,0,0,      0,1,0,0,    0,32'hA));
        tbl.push_back(z);
        tbl.push_back(z);

        foreach (tbl[i]) begin
            drive_a(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d p0_gnt", i), 32'(p0_gnt_a), 32'(tbl[i].g0));
            chk($sformatf("v%0d p1_gnt", i), 32'(p1_gnt_a), 32'(tbl[i].g1));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we_a), 32'(tbl[i].we));
            chk($sformatf("v%0d mem_addr", i), mem_addr_a, tbl[i].ma);
            exp_wd = tbl[i].g0 ? tbl[i].d0 : (tbl[i].g1 ? tbl[i].d1 : 0);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata_a, exp_wd);
            chk_rv(i);
            if (tbl[i].g0 && !tbl[i].w0) q0.push_back(tbl[i].x0);
            if (tbl[i].g1 && !tbl[i].w1) q1.push_back(tbl[i].x1);
            @(posedge clk); #1;
        end
        drive_a(z);

        // starvation guard on the priority instance
        p0_req_b = 1'b1; p0_addr_b = 32'h0;
        p1_req_b = 1'b1; p1_addr_b = 32'h4;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("st%0d p0_gnt", c), 32'(p0_gnt_b), 32'(c != 5));
            chk($sformatf("st%0d p1_gnt", c), 32'(p1_gnt_b), 32'(c == 5));
            chk($sformatf("st%0d cnt", c), 32'(u_b.starve_q),
                (c <= 5) ? 32'(c - 1) : 0);
            chk($sformatf("st%0d mem_addr", c), mem_addr_b,
                (c == 5) ? 32'h4 : 32'h0);
            chk($sformatf("st%0d mem_we", c), 32'(mem_we_b), 0);
            chk($sformatf("st%0d mem_wdata", c), mem_wdata_b, 0);
            chk($sformatf("st%0d p0_rvalid", c), 32'(p0_rvalid_b),
                32'(c != 1 && c != 6));
            if (c > 1 && c != 6)
                chk($sformatf("st%0d p0_rdata", c), p0_rdata_b, ~32'h0);
            if (c == 6) begin
                chk("st6 p1_rvalid", 32'(p1_rvalid_b), 1);
                chk("st6 p1_rdata", p1_rdata_b, ~32'h4);
            end
            @(posedge clk); #1;
            if (c == 5) p1_req_b = 1'b0;
        end
        idle_b();

        // idle: nothing requested for 10 cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle%0d mem_we", c), 32'(mem_we_a), 0);
            chk($sformatf("idle%0d mem_addr", c), mem_addr_a, 0);
            chk($sformatf("idle%0d rvalid", c),
                32'({p1_rvalid_a, p0_rvalid_a}), 0);
            chk($sformatf("idle%0d state", c), 32'(u_a.state_q),
                32'(IDLE));
            @(posedge clk); #1;
        end
        chk("queues drained", 32'(q0.size() + q1.size()), 0);

        // reset asserted while a read is returning
        p0_req_a = 1'b1;
        p0_addr_a = 32'h4;
        @(negedge clk);
        chk("mid p0_gnt", 32'(p0_gnt_a), 1);
        @(posedge clk); #1;
        chk("mid p0_rvalid", 32'(p0_rvalid_a), 1);
        chk("mid p0_rdata", p0_rdata_a, 32'hB);
        rst_n = 1'b0;
        #1;
        chk("arst p0_gnt", 32'(p0_gnt_a), 0);
        chk("arst p0_rvalid", 32'(p0_rvalid_a), 0);
        chk("arst p0_rdata", p0_rdata_a, 0);
        chk("arst mem_we", 32'(mem_we_a), 0);
        #1;
        p0_addr_a = 32'h10;
        rst_n = 1'b1;
        #1;
        chk("rel p0_gnt", 32'(p0_gnt_a), 1);
        chk("rel mem_addr", mem_addr_a, 32'h10);
        @(posedge clk); #1;
        drive_a(z);
        chk("rel p0_rvalid", 32'(p0_rvalid_a), 1);
        chk("rel p0_rdata", p0_rdata_a, 32'h1234);
        @(posedge clk); #1;
        chk("rel p0_rvalid off", 32'(p0_rvalid_a), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
